serial_sub: RTL and testbench

- Area-reduced signed two's-complement subtractor for the ODE datapath; computes result = A - B.
- Processes one 4-bit nibble per clock through a single borrow-look-ahead slice, so a DATA_WIDTH operation takes DATA_WIDTH/4 cycles.
- Valid/ready handshakes on both sides let it sit between the coefficient registers and the accumulator stage, in place of the fully combinational adder where area matters.

---
 rtl/serial_sub_pkg.sv | 19 +
 rtl/serial_sub_borrow_look_ahead_4bit.sv | 27 ++
 rtl/serial_sub.sv | 128 ++++++++++++
 tb/tb_serial_sub.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the nibble-serial subtractor.
package serial_sub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Width of the nibble counter; a single-nibble datapath still needs one bit.
  function automatic int cnt_width(input int data_width);
    int w;
    w = $clog2(data_width / NIBBLE_W);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_sub_borrow_look_ahead_4bit.sv
// Combinational 4-bit look-ahead adder slice; the parent inverts b so it
// acts as a borrow-look-ahead subtractor stage.
module borrow_look_ahead_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] result,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign result = p ^ c;

endmodule

// File: rtl/serial_sub.sv
// Nibble-serial signed subtractor: result = A - B over DATA_WIDTH/4 cycles,
// with valid/ready handshakes on operand and result sides.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  borrow
);

  localparam int N  = DATA_WIDTH / NIBBLE_W;
  localparam int CW = cnt_width(DATA_WIDTH);

  generate
    if ((DATA_WIDTH % NIBBLE_W) != 0 || DATA_WIDTH < NIBBLE_W) begin : g_bad_width
      $error("serial_sub: DATA_WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q;
  logic                  carry_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, res_q, res_shift;
  logic                  overflow_q, borrow_q;
  logic [NIBBLE_W-1:0]   nib_sum;
  logic                  nib_cout;
  logic                  last_nib;

  assign last_nib = (count_q == CW'(N - 1));

  borrow_look_ahead_4bit u_slice (
    .a      (a_q[NIBBLE_W-1:0]),
    .b      (~b_q[NIBBLE_W-1:0]),
    .cin    (carry_q),
    .result (nib_sum),
    .cout   (nib_cout)
  );

  // Each new nibble enters at the top, so after N steps nibble 0 sits at the bottom.
  generate
    if (N == 1) begin : g_single
      assign res_shift = nib_sum;
    end else begin : g_multi
      assign res_shift = {nib_sum, res_q[DATA_WIDTH-1:NIBBLE_W]};
    end
  endgenerate

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last_nib) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      carry_q    <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      overflow_q <= 1'b0;
      borrow_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= 1'b1;
            count_q <= '0;
          end
        end
        RUN: begin
          res_q   <= res_shift;
          carry_q <= nib_cout;
          a_q     <= a_q >> NIBBLE_W;
          b_q     <= b_q >> NIBBLE_W;
          count_q <= count_q + CW'(1);
          // On the last nibble the slice bit 3 lines up with the operand MSBs.
          if (last_nib) begin
            borrow_q   <= ~nib_cout;
            overflow_q <= (a_q[NIBBLE_W-1] & ~b_q[NIBBLE_W-1] & ~nib_sum[NIBBLE_W-1])
                        | (~a_q[NIBBLE_W-1] & b_q[NIBBLE_W-1] & nib_sum[NIBBLE_W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign result   = res_q;
  assign overflow = overflow_q;
  assign borrow   = borrow_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed and randomised checks of serial_sub against an integer reference.
module tb_serial_sub;

  localparam int DW = 16;
  localparam int N  = DW / 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] A, B;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic          overflow;
  logic          borrow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_sub #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .borrow    (borrow)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    logic          ov;
    logic          br;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {overflow, borrow, result}
  function automatic logic [DW+1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] d;
    logic          ov, br;
    d  = a - b;
    br = (a < b);
    ov = (a[DW-1] != b[DW-1]) && (d[DW-1] != a[DW-1]);
    return {ov, br, d};
  endfunction

  task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    A = a;
    B = b;
    guard = 0;
    while (!in_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 64) check("accept_timeout", 64'(guard), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 64);
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input int stall,
                       input bool_lat, output logic [DW-1:0] r, output logic ov, output logic br);
    int lat;
    start_op(a, b);
    in_valid = 1'b0;
    A = DW'($urandom);
    B = DW'($urandom);
    wait_valid(lat);
    if (bool_lat) check("latency", 64'(lat), 64'(N));
    else if (lat >= 64) check("valid_timeout", 64'(lat), 64'(N));
    r  = result;
    ov = overflow;
    br = borrow;
    repeat (stall) begin
      @(negedge clk);
      if (!out_valid || result !== r) check("stall_hold", {out_valid, result}, {1'b1, r});
    end
    handshake();
    if (out_valid) check("valid_drop", 64'(out_valid), 64'(0));
  endtask

  initial begin
    logic [DW-1:0] r, r0;
    logic          ov, br, ov0, br0;
    logic [DW+1:0] m;
    logic          saw_valid;
    int            lat;

    vecs[0]  = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0};
    vecs[1]  = '{16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0};
    vecs[2]  = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1};
    vecs[3]  = '{16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1};
    vecs[4]  = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0};
    vecs[5]  = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
    vecs[6]  = '{16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b1};
    vecs[7]  = '{16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{16'h7FFF, 16'h8000, 16'hFFFF, 1'b1, 1'b1};
    vecs[9]  = '{16'hABCD, 16'h1234, 16'h9999, 1'b0, 1'b0};
    vecs[10] = '{16'h0001, 16'hFFFF, 16'h0002, 1'b0, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_result",    64'(result),    64'(0));
    check("rst_flags",     {overflow, borrow}, 2'b00);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].a, vecs[i].b, i % 3, 1'b1, r, ov, br);
      check($sformatf("vec%0d_result", i),   64'(r),  64'(vecs[i].res));
      check($sformatf("vec%0d_overflow", i), 64'(ov), 64'(vecs[i].ov));
      check($sformatf("vec%0d_borrow", i),   64'(br), 64'(vecs[i].br));
    end

    // Backpressure with a new request held during DONE.
    start_op(16'h0010, 16'h0001);
    A = 16'h0100;
    B = 16'h0001;
    wait_valid(lat);
    check("bp_latency", 64'(lat), 64'(N));
    r0 = result; ov0 = overflow; br0 = borrow;
    check("bp_result", 64'(r0), 64'(16'h000F));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", k), {in_ready, out_valid, result, overflow, borrow},
            {1'b0, 1'b1, r0, ov0, br0});
    end
    handshake();
    check("bp_after_hs", {out_valid, in_ready}, 2'b01);
    @(posedge clk);
    #1;
    check("bp_accept_next", 64'(in_ready), 64'(0));
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_second_latency", 64'(lat), 64'(N));
    check("bp_second_result", 64'(result), 64'(16'h00FF));
    handshake();

    // Reset in the middle of RUN.
    start_op(16'h1234, 16'h0234);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", {in_ready, out_valid, result, overflow, borrow},
          {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (2 * N) begin
      @(negedge clk);
      saw_valid |= out_valid;
    end
    check("mid_rst_no_valid", 64'(saw_valid), 64'(0));
    do_op(16'h1234, 16'h0234, 0, 1'b1, r, ov, br);
    check("post_rst_result", {r, ov, br}, {16'h1000, 1'b0, 1'b0});

    // Randomised back-to-back traffic with random stalls.
    for (int i = 0; i < 1000; i++) begin
      logic [DW-1:0] ra, rb;
      ra = DW'($urandom);
      rb = DW'($urandom);
      if (i % 50 == 0) rb = ra;
      m = model(ra, rb);
      do_op(ra, rb, int'($urandom_range(0, 3)), 1'b0, r, ov, br);
      check($sformatf("rnd%0d", i), {ov, br, r}, m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
